ternary_mv_engine: RTL and testbench

Parametrised ternary matrix–vector engine; successor to the per-unit processing element in the NN accelerator. It holds one signed vector (VEC_LEN words), one ternary weight matrix (VEC_LEN×VEC_LEN, 2 bits/entry) and a separate result buffer. It executes multi-cycle MUL / MUL_ACC with LANES rows reduced in parallel, column-serial, followed by saturation and activation. It sits under the multi-unit controller and is driven by a valid/ready command handshake plus word-level load/read ports.

---
 rtl/ternary_mv_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ternary_mv_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_mv_engine.sv
// ternary_mv_engine: ternary matrix-vector engine.
//
// Holds one signed vector (VEC_LEN words), one ternary weight matrix
// (VEC_LEN x VEC_LEN, 2 bits per entry) and a separate result buffer. MUL and
// MUL_ACC reduce LANES rows in parallel, one column per cycle, then saturate or
// wrap, apply the activation and write the result buffer.
//
// Build option: define TMVU_SAT_EN to saturate final sums to the DATA_WIDTH
// signed range; otherwise the sums wrap to their low DATA_WIDTH bits.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_op, cmd_act        opcode (NOP/MUL/MUL_ACC/COPY/CLR_VEC/CLR_RES), activation
//   busy, done, err        status; done and err are one-cycle pulses
//   vec_wr_*               vector word write (idle only)
//   mat_wr_*               matrix row write (idle only)
//   rd_sel, rd_addr        read select (0 vector, 1 result) and word index
//   rd_data                registered read data
module ternary_mv_engine #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              VEC_LEN    = 16,
  parameter int unsigned              LANES      = 4,
  parameter logic [DATA_WIDTH-1:0]    CLAMP_ONE  = 32'h4000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [1:0]                    cmd_act,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic                          vec_wr_en,
  input  logic [$clog2(VEC_LEN)-1:0]    vec_wr_addr,
  input  logic [DATA_WIDTH-1:0]         vec_wr_data,
  input  logic                          mat_wr_en,
  input  logic [$clog2(VEC_LEN)-1:0]    mat_wr_addr,
  input  logic [2*VEC_LEN-1:0]          mat_wr_data,
  input  logic                          rd_sel,
  input  logic [$clog2(VEC_LEN)-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  localparam int unsigned IDX_W = $clog2(VEC_LEN);
  localparam int unsigned ACC_W = DATA_WIDTH + IDX_W + 1;
  localparam int unsigned NGRP  = VEC_LEN / LANES;
  localparam int unsigned GRP_W = $clog2(NGRP + 1);

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpMul    = 3'd1;
  localparam logic [2:0] OpMulAcc = 3'd2;
  localparam logic [2:0] OpCopy   = 3'd3;
  localparam logic [2:0] OpClrVec = 3'd4;
  localparam logic [2:0] OpClrRes = 3'd5;

  localparam logic [1:0] ActRelu  = 2'd1;
  localparam logic [1:0] ActClamp = 2'd2;

  localparam logic signed [DATA_WIDTH-1:0] ClampPos = CLAMP_ONE;
  localparam logic signed [DATA_WIDTH-1:0] ClampNeg = -ClampPos;

  if (LANES == 0 || (VEC_LEN % LANES) != 0) begin : g_lanes_check
    $error("LANES must divide VEC_LEN");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q, state_d;
  logic [GRP_W-1:0]         grp_q, grp_d;
  logic [IDX_W-1:0]         col_q, col_d;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [ACC_W-1:0]  acc_d [LANES];
  logic                     op_acc_q;
  logic [1:0]               act_q;
  logic                     err_q;

  // Final sums are registered and written back one cycle later; the extra
  // drain cycle after the last group flushes the final writeback.
  logic                     wb_valid_q, wb_valid_d;
  logic [GRP_W-1:0]         wb_grp_q, wb_grp_d;
  logic signed [ACC_W-1:0]  wb_sum_q [LANES];
  logic signed [ACC_W-1:0]  wb_sum_d [LANES];

  logic [DATA_WIDTH-1:0]    vec_q [VEC_LEN];
  logic [2*VEC_LEN-1:0]     mat_q [VEC_LEN];
  logic [DATA_WIDTH-1:0]    res_q [VEC_LEN];

  logic                     accept;
  logic                     op_legal;
  logic                     op_is_mul;
  logic [GRP_W-1:0]         init_grp;
  logic                     init_acc;
  logic signed [ACC_W-1:0]  vec_ext;
  logic [IDX_W-1:0]         row_idx  [LANES];
  logic [IDX_W-1:0]         init_row [LANES];
  logic [IDX_W-1:0]         wb_row   [LANES];
  logic [1:0]               entry    [LANES];
  logic signed [ACC_W-1:0]  term     [LANES];
  logic signed [ACC_W-1:0]  sum      [LANES];
  logic signed [ACC_W-1:0]  init_val [LANES];

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign done      = (state_q == StDone);
  assign err       = err_q;

  assign accept    = cmd_valid && cmd_ready;
  assign op_legal  = (cmd_op <= OpClrRes);
  assign op_is_mul = (cmd_op == OpMul) || (cmd_op == OpMulAcc);

  // Accumulator preload source: group 0 at accept, next group at a group end.
  assign init_grp = (state_q == StIdle) ? '0 : grp_q + 1'b1;
  assign init_acc = (state_q == StIdle) ? (cmd_op == OpMulAcc) : op_acc_q;

  assign vec_ext = {{(ACC_W-DATA_WIDTH){vec_q[col_q][DATA_WIDTH-1]}}, vec_q[col_q]};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign row_idx[l]  = IDX_W'(grp_q * LANES + l);
    assign init_row[l] = IDX_W'(init_grp * LANES + l);
    assign wb_row[l]   = IDX_W'(wb_grp_q * LANES + l);
    assign entry[l]    = mat_q[row_idx[l]][{col_q, 1'b0} +: 2];
    // bit0 enables the entry, bit1 negates it
    assign term[l]     = entry[l][0] ? (entry[l][1] ? -vec_ext : vec_ext) : '0;
    assign sum[l]      = acc_q[l] + term[l];
    assign init_val[l] = (init_acc && (init_grp < GRP_W'(NGRP)))
                       ? {{(ACC_W-DATA_WIDTH){res_q[init_row[l]][DATA_WIDTH-1]}},
                          res_q[init_row[l]]}
                       : '0;
  end

  function automatic logic [DATA_WIDTH-1:0] post_proc(input logic signed [ACC_W-1:0] s,
                                                      input logic [1:0] act);
    logic signed [DATA_WIDTH-1:0] x;
`ifdef TMVU_SAT_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    sat_min = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    if (s > sat_max) begin
      x = sat_max[DATA_WIDTH-1:0];
    end else if (s < sat_min) begin
      x = sat_min[DATA_WIDTH-1:0];
    end else begin
      x = s[DATA_WIDTH-1:0];
    end
`else
    x = s[DATA_WIDTH-1:0];
`endif
    case (act)
      ActRelu:  if (x < 0) x = '0;
      ActClamp: begin
        if (x > ClampPos) x = ClampPos;
        else if (x < ClampNeg) x = ClampNeg;
      end
      default: ;  // NONE and reserved pass through
    endcase
    return x;
  endfunction

  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    col_d      = col_q;
    acc_d      = acc_q;
    wb_valid_d = 1'b0;
    wb_grp_d   = wb_grp_q;
    wb_sum_d   = wb_sum_q;
    unique case (state_q)
      StIdle: begin
        if (accept && op_is_mul) begin
          state_d = StRun;
          grp_d   = '0;
          col_d   = '0;
          acc_d   = init_val;
        end else if (accept && op_legal) begin
          state_d = StDone;
        end
      end
      StRun: begin
        if (grp_q == GRP_W'(NGRP)) begin
          state_d = StDone;
        end else if (col_q == IDX_W'(VEC_LEN - 1)) begin
          wb_valid_d = 1'b1;
          wb_grp_d   = grp_q;
          wb_sum_d   = sum;
          grp_d      = grp_q + 1'b1;
          col_d      = '0;
          acc_d      = init_val;
        end else begin
          col_d = col_q + 1'b1;
          acc_d = sum;
        end
      end
      StDone: begin
        state_d = StIdle;
        grp_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grp_q      <= '0;
      col_q      <= '0;
      op_acc_q   <= 1'b0;
      act_q      <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_grp_q   <= '0;
      rd_data    <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l]    <= '0;
        wb_sum_q[l] <= '0;
      end
      for (int i = 0; i < VEC_LEN; i++) begin
        vec_q[i] <= '0;
        mat_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      wb_valid_q <= wb_valid_d;
      wb_grp_q   <= wb_grp_d;
      wb_sum_q   <= wb_sum_d;
      err_q      <= accept && !op_legal;

      if (accept) begin
        op_acc_q <= (cmd_op == OpMulAcc);
        act_q    <= cmd_act;
      end

      if (state_q == StIdle) begin
        if (vec_wr_en) vec_q[vec_wr_addr] <= vec_wr_data;
        if (mat_wr_en) mat_q[mat_wr_addr] <= mat_wr_data;
      end

      if (accept) begin
        case (cmd_op)
          OpCopy:   vec_q <= res_q;
          OpClrVec: for (int i = 0; i < VEC_LEN; i++) vec_q[i] <= '0;
          OpClrRes: for (int i = 0; i < VEC_LEN; i++) res_q[i] <= '0;
          default: ;  // NOP, MUL, MUL_ACC, illegal
        endcase
      end

      if (wb_valid_q) begin
        for (int l = 0; l < LANES; l++) begin
          res_q[wb_row[l]] <= post_proc(wb_sum_q[l], act_q);
        end
      end

      rd_data <= rd_sel ? res_q[rd_addr] : vec_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_ternary_mv_engine.sv
// Self-checking bench for ternary_mv_engine: directed scenarios plus randomized
// commands checked against an arithmetic reference model.
module tb_ternary_mv_engine;

  localparam int DW = 32;
  localparam int VL = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [1:0]    cmd_act;
  logic          busy;
  logic          done;
  logic          err;
  logic          vec_wr_en;
  logic [AW-1:0] vec_wr_addr;
  logic [DW-1:0] vec_wr_data;
  logic          mat_wr_en;
  logic [AW-1:0] mat_wr_addr;
  logic [2*VL-1:0] mat_wr_data;
  logic          rd_sel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  ternary_mv_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_act     (cmd_act),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .vec_wr_en   (vec_wr_en),
    .vec_wr_addr (vec_wr_addr),
    .vec_wr_data (vec_wr_data),
    .mat_wr_en   (mat_wr_en),
    .mat_wr_addr (mat_wr_addr),
    .mat_wr_data (mat_wr_data),
    .rd_sel      (rd_sel),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: vector, ternary weights as -1/0/+1, result.
  logic [31:0] m_vec [VL];
  int          m_mat [VL][VL];
  logic [31:0] m_res [VL];

`ifdef TMVU_SAT_EN
  localparam logic [31:0] SatExp = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SatExp = 32'hFFFF_FFF0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_post(input longint s, input int act);
    longint v;
    int x;
    v = s;
`ifdef TMVU_SAT_EN
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
`endif
    x = int'(v);
    if (act == 1 && x < 0) x = 0;
    if (act == 2) begin
      if (x > 32'sh4000_0000) x = 32'sh4000_0000;
      else if (x < -32'sh4000_0000) x = -32'sh4000_0000;
    end
    return x;
  endfunction

  task automatic m_mul(input bit acc, input int act);
    logic [31:0] nr [VL];
    longint s;
    for (int r = 0; r < VL; r++) begin
      s = acc ? longint'($signed(m_res[r])) : 64'sd0;
      for (int c = 0; c < VL; c++) s += longint'(m_mat[r][c]) * longint'($signed(m_vec[c]));
      nr[r] = m_post(s, act);
    end
    m_res = nr;
  endtask

  task automatic write_vec(input int i, input logic [31:0] d);
    vec_wr_en = 1'b1; vec_wr_addr = AW'(i); vec_wr_data = d;
    m_vec[i] = d;
    @(negedge clk);
    vec_wr_en = 1'b0;
  endtask

  task automatic write_row(input int r);
    logic [2*VL-1:0] bits;
    for (int c = 0; c < VL; c++) begin
      case (m_mat[r][c])
        1:       bits[2*c +: 2] = 2'b01;
        -1:      bits[2*c +: 2] = 2'b11;
        default: bits[2*c +: 2] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
      endcase
    end
    mat_wr_en = 1'b1; mat_wr_addr = AW'(r); mat_wr_data = bits;
    @(negedge clk);
    mat_wr_en = 1'b0;
  endtask

  task automatic write_all_rows();
    for (int r = 0; r < VL; r++) write_row(r);
  endtask

  task automatic rd(input bit sel, input int addr, output logic [31:0] d);
    rd_sel = sel; rd_addr = AW'(addr);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic verify_all(input string tag);
    logic [31:0] d;
    for (int i = 0; i < VL; i++) begin
      rd(1'b1, i, d); check($sformatf("%s res[%0d]", tag, i), d, m_res[i]);
      rd(1'b0, i, d); check($sformatf("%s vec[%0d]", tag, i), d, m_vec[i]);
    end
  endtask

  // Issue one command, time it to done, and apply it to the model.
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] act, input bit poke,
                         input string tag);
    int cnt;
    bit busy_bad;
    check({tag, " ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_act = act;
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt = 0; busy_bad = 0;
    while (!done && cnt < 300) begin
      if (!busy) busy_bad = 1;
      @(negedge clk);
      cnt++;
      if (poke && cnt == 5) begin
        vec_wr_en = 1'b1; vec_wr_addr = AW'($urandom_range(0, VL-1)); vec_wr_data = $urandom;
      end
      if (cnt == 6) vec_wr_en = 1'b0;
    end
    vec_wr_en = 1'b0;
    check({tag, " done edges"}, cnt, (op == 3'd1 || op == 3'd2) ? 65 : 0);
    check({tag, " busy in run"}, busy_bad, 1'b0);
    @(negedge clk);
    check({tag, " done pulse"}, {done, cmd_ready}, 2'b01);
    case (op)
      3'd1: m_mul(1'b0, act);
      3'd2: m_mul(1'b1, act);
      3'd3: m_vec = m_res;
      3'd4: for (int i = 0; i < VL; i++) m_vec[i] = '0;
      3'd5: for (int i = 0; i < VL; i++) m_res[i] = '0;
      default: ;
    endcase
  endtask

  task automatic clear_mat();
    for (int r = 0; r < VL; r++) for (int c = 0; c < VL; c++) m_mat[r][c] = 0;
  endtask

  task automatic setup_identity();
    clear_mat();
    for (int r = 0; r < VL; r++) m_mat[r][r] = 1;
    write_all_rows();
    for (int i = 0; i < VL; i++) write_vec(i, 32'(i + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_act = '0;
    vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_data = '0;
    mat_wr_en = 1'b0; mat_wr_addr = '0; mat_wr_data = '0;
    rd_sel = 1'b0; rd_addr = '0;
    for (int i = 0; i < VL; i++) begin m_vec[i] = '0; m_res[i] = '0; end
    clear_mat();
    repeat (2) @(negedge clk);
    check("reset status", {cmd_ready, busy, done, err}, 4'b1000);
    check("reset rd_data", rd_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity
    setup_identity();
    run_cmd(3'd1, 2'd0, 1'b0, "identity");
    verify_all("identity");

    // Accumulate then copy result into vector
    run_cmd(3'd2, 2'd0, 1'b0, "mul_acc");
    run_cmd(3'd3, 2'd0, 1'b0, "copy");
    rd(1'b1, 5, d); check("mul_acc res[5]", d, 32'd12);
    rd(1'b0, 15, d); check("copy vec[15]", d, 32'd32);
    verify_all("acc_copy");

    // All-negate row 0
    clear_mat();
    for (int c = 0; c < VL; c++) m_mat[0][c] = -1;
    write_all_rows();
    for (int i = 0; i < VL; i++) write_vec(i, 32'(i + 1));
    run_cmd(3'd1, 2'd0, 1'b0, "negate");
    rd(1'b1, 0, d); check("negate res[0]", d, 32'hFFFF_FF78);
    verify_all("negate");

    // Saturation / wrap
    clear_mat();
    for (int c = 0; c < VL; c++) m_mat[0][c] = 1;
    write_all_rows();
    for (int i = 0; i < VL; i++) write_vec(i, 32'h7FFF_FFFF);
    run_cmd(3'd1, 2'd0, 1'b0, "sat");
    rd(1'b1, 0, d); check("sat res[0]", d, SatExp);

    // Activations
    clear_mat();
    m_mat[0][0] = 1; m_mat[1][0] = -1;
    write_all_rows();
    write_vec(0, 32'h6000_0000);
    run_cmd(3'd1, 2'd2, 1'b0, "clamp");
    rd(1'b1, 0, d); check("clamp pos", d, 32'h4000_0000);
    rd(1'b1, 1, d); check("clamp neg", d, 32'hC000_0000);
    run_cmd(3'd1, 2'd1, 1'b0, "relu");
    rd(1'b1, 0, d); check("relu pos", d, 32'h6000_0000);
    rd(1'b1, 1, d); check("relu neg", d, 32'h0);
    verify_all("act");

    // Illegal opcode
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_act = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("illegal err/done/ready", {err, done, cmd_ready}, 3'b101);
    @(negedge clk);
    check("illegal err once", {err, done, cmd_ready}, 3'b001);

    // Randomized commands
    for (int it = 0; it < 14; it++) begin
      logic [2:0] op;
      for (int r = 0; r < VL; r++)
        for (int c = 0; c < VL; c++) m_mat[r][c] = int'($urandom_range(0, 2)) - 1;
      write_all_rows();
      for (int i = 0; i < VL; i++)
        write_vec(i, ($urandom_range(0, 3) == 0) ? $urandom
                                                 : 32'($urandom_range(0, 2000)) - 32'd1000);
      case ($urandom_range(0, 9))
        0: op = 3'd3;
        1: op = 3'd4;
        2: op = 3'd5;
        3: op = 3'd0;
        4, 5, 6: op = 3'd2;
        default: op = 3'd1;
      endcase
      run_cmd(op, 2'($urandom_range(0, 3)), 1'b1, $sformatf("rand%0d", it));
      if (op == 3'd3 || op == 3'd4) run_cmd(3'd2, 2'($urandom_range(0, 3)), 1'b0, "rand_acc");
      verify_all($sformatf("rand%0d", it));
    end

    // Reset in the middle of a run
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_act = 2'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun reset status", {cmd_ready, busy, done, err}, 4'b1000);
    check("midrun reset rd_data", rd_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < VL; i++) begin m_vec[i] = '0; m_res[i] = '0; end
    clear_mat();
    verify_all("after reset");
    // Matrix must be cleared too: a MUL over a fresh vector yields zeros.
    for (int i = 0; i < VL; i++) write_vec(i, $urandom);
    run_cmd(3'd1, 2'd0, 1'b0, "after reset mul");
    verify_all("after reset mul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
